mem_arbiter: RTL and testbench

- Two-master, one-slave memory arbiter for the single-issue core.
- Shares one memory port between instruction fetch (IFU, master 0) and load/store (LSU, master 1).
- Uses round-robin grant and handles one outstanding transaction at a time.
- A per-transaction timeout turns a hung slave into an error response instead of a core deadlock.

---
 rtl/mem_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-master, one-slave memory arbiter: IFU (master 0) and LSU (master 1) share
// one memory port. Round-robin grant, one outstanding transaction, and a
// per-transaction timeout that turns a hung slave into an error response.
module mem_arbiter #(
  parameter int unsigned TIMEOUT     = 16,
  parameter int unsigned FIRST_GRANT = 0
) (
  input  logic        sys_clk,
  input  logic        sys_rst,

  input  logic        ifu_req_valid,
  input  logic [31:0] ifu_req_addr,
  output logic        ifu_req_ready,
  output logic        ifu_resp_valid,
  output logic [31:0] ifu_resp_data,
  output logic        ifu_resp_err,

  input  logic        lsu_req_valid,
  input  logic [31:0] lsu_req_addr,
  input  logic        lsu_req_wen,
  input  logic [31:0] lsu_req_wdata,
  input  logic [3:0]  lsu_req_wmask,
  output logic        lsu_req_ready,
  output logic        lsu_resp_valid,
  output logic [31:0] lsu_resp_data,
  output logic        lsu_resp_err,

  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_wen,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,

  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  // The counter is 0 in the first cycle after accept. Aborting once it reaches
  // TIMEOUT-2 lands the error pulse exactly TIMEOUT cycles after the accept
  // cycle. The >= keeps a transaction that only just escaped REQ from running on.
  localparam logic [7:0] ToLast = 8'(TIMEOUT - 2);

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic        last_grant_q;
  logic        grant_id_q;

  logic        grant;
  logic        handshake;
  logic        timeout_hit;
  logic        finish;
  logic        fin_err;
  logic [31:0] fin_data;

  assign busy = (state_q != StIdle);

  // Round-robin grant and same-cycle ready in IDLE.
  always_comb begin
    grant = ~last_grant_q;
    if (ifu_req_valid && !lsu_req_valid) begin
      grant = 1'b0;
    end else if (!ifu_req_valid && lsu_req_valid) begin
      grant = 1'b1;
    end
    ifu_req_ready = (state_q == StIdle) && ifu_req_valid && !grant;
    lsu_req_ready = (state_q == StIdle) && lsu_req_valid && grant;
    handshake     = ifu_req_ready | lsu_req_ready;
  end

  // Decide whether the pending transaction ends this cycle, and with what result.
  always_comb begin
    timeout_hit = (cnt_q >= ToLast);
    finish      = 1'b0;
    fin_err     = 1'b0;
    fin_data    = 32'd0;
    case (state_q)
      StReq: begin
        if (!mem_req_ready && timeout_hit) begin
          finish  = 1'b1;
          fin_err = 1'b1;
        end
      end
      StWait: begin
        if (mem_resp_valid) begin
          finish   = 1'b1;
          fin_data = mem_req_wen ? 32'd0 : mem_resp_data;
        end else if (timeout_hit) begin
          finish  = 1'b1;
          fin_err = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Transaction FSM with registered slave-side fields and response pulses.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      state_q        <= StIdle;
      cnt_q          <= 8'd0;
      last_grant_q   <= (FIRST_GRANT == 0);
      grant_id_q     <= 1'b0;
      mem_req_valid  <= 1'b0;
      mem_req_addr   <= 32'd0;
      mem_req_wen    <= 1'b0;
      mem_req_wdata  <= 32'd0;
      mem_req_wmask  <= 4'd0;
      ifu_resp_valid <= 1'b0;
      ifu_resp_data  <= 32'd0;
      ifu_resp_err   <= 1'b0;
      lsu_resp_valid <= 1'b0;
      lsu_resp_data  <= 32'd0;
      lsu_resp_err   <= 1'b0;
    end else begin
      // Response outputs are single-cycle pulses.
      ifu_resp_valid <= 1'b0;
      ifu_resp_data  <= 32'd0;
      ifu_resp_err   <= 1'b0;
      lsu_resp_valid <= 1'b0;
      lsu_resp_data  <= 32'd0;
      lsu_resp_err   <= 1'b0;

      case (state_q)
        StIdle: begin
          if (handshake) begin
            grant_id_q    <= grant;
            last_grant_q  <= grant;
            cnt_q         <= 8'd0;
            mem_req_valid <= 1'b1;
            if (grant) begin
              mem_req_addr  <= lsu_req_addr;
              mem_req_wen   <= lsu_req_wen;
              mem_req_wdata <= lsu_req_wdata;
              mem_req_wmask <= lsu_req_wmask;
            end else begin
              mem_req_addr  <= ifu_req_addr;
              mem_req_wen   <= 1'b0;
              mem_req_wdata <= 32'd0;
              mem_req_wmask <= 4'd0;
            end
            state_q <= StReq;
          end
        end
        StReq: begin
          cnt_q <= cnt_q + 8'd1;
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state_q       <= StWait;
          end else if (finish) begin
            mem_req_valid <= 1'b0;
            state_q       <= StResp;
          end
        end
        StWait: begin
          cnt_q <= cnt_q + 8'd1;
          if (finish) begin
            state_q <= StResp;
          end
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase

      if (finish) begin
        if (grant_id_q) begin
          lsu_resp_valid <= 1'b1;
          lsu_resp_data  <= fin_data;
          lsu_resp_err   <= fin_err;
        end else begin
          ifu_resp_valid <= 1'b1;
          ifu_resp_data  <= fin_data;
          ifu_resp_err   <= fin_err;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// transactions, checked against a transaction-level timing/grant model.
module tb_mem_arbiter;

  localparam int To = 16;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic        ifu_req_valid = 1'b0;
  logic [31:0] ifu_req_addr = 32'd0;
  logic        ifu_req_ready;
  logic        ifu_resp_valid;
  logic [31:0] ifu_resp_data;
  logic        ifu_resp_err;
  logic        lsu_req_valid = 1'b0;
  logic [31:0] lsu_req_addr = 32'd0;
  logic        lsu_req_wen = 1'b0;
  logic [31:0] lsu_req_wdata = 32'd0;
  logic [3:0]  lsu_req_wmask = 4'd0;
  logic        lsu_req_ready;
  logic        lsu_resp_valid;
  logic [31:0] lsu_resp_data;
  logic        lsu_resp_err;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = 32'd0;
  logic        busy;

  int total = 0;
  int bad   = 0;
  bit last_g;

  mem_arbiter #(.TIMEOUT(To), .FIRST_GRANT(0)) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_addr  (ifu_req_addr),
    .ifu_req_ready (ifu_req_ready),
    .ifu_resp_valid(ifu_resp_valid),
    .ifu_resp_data (ifu_resp_data),
    .ifu_resp_err  (ifu_resp_err),
    .lsu_req_valid (lsu_req_valid),
    .lsu_req_addr  (lsu_req_addr),
    .lsu_req_wen   (lsu_req_wen),
    .lsu_req_wdata (lsu_req_wdata),
    .lsu_req_wmask (lsu_req_wmask),
    .lsu_req_ready (lsu_req_ready),
    .lsu_resp_valid(lsu_resp_valid),
    .lsu_resp_data (lsu_resp_data),
    .lsu_resp_err  (lsu_resp_err),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wen   (mem_req_wen),
    .mem_req_wdata (mem_req_wdata),
    .mem_req_wmask (mem_req_wmask),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data (mem_resp_data),
    .busy          (busy)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Cycle counts are relative to the accept cycle (k=0). Slave raises ready in
  // cycle k1 and its response in k2. dl is the last cycle in which the
  // transaction can still complete; after that the arbiter aborts.
  task automatic model(input int d1, input int d2, output int lat, output bit err,
                       output int k1, output int k2);
    int dl;
    dl = To - 1;
    k1 = d1 + 1;
    k2 = k1 + 1 + d2;
    if (k1 > dl) begin
      lat = To;
      err = 1'b1;
    end else if (k1 == dl) begin
      lat = To + 1;
      err = (d2 != 0);
    end else if (k2 <= dl) begin
      lat = k2 + 1;
      err = 1'b0;
    end else begin
      lat = To;
      err = 1'b1;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check1({tag, "_busy"}, busy, 1'b0);
    check1({tag, "_mvalid"}, mem_req_valid, 1'b0);
    check1({tag, "_ifu_rv"}, ifu_resp_valid, 1'b0);
    check1({tag, "_lsu_rv"}, lsu_resp_valid, 1'b0);
    check32({tag, "_ifu_rd"}, ifu_resp_data, 32'd0);
    check32({tag, "_lsu_rd"}, lsu_resp_data, 32'd0);
    check1({tag, "_ifu_re"}, ifu_resp_err, 1'b0);
    check1({tag, "_lsu_re"}, lsu_resp_err, 1'b0);
  endtask

  // Starts in an IDLE cycle, #1 after the edge; ends in the IDLE cycle after RESP.
  task automatic run_txn(input bit iv, input bit lv, input logic [31:0] ia,
                         input logic [31:0] la, input bit lwen, input logic [31:0] lwd,
                         input logic [3:0] lmask, input int d1, input int d2,
                         input logic [31:0] rdata);
    bit          g;
    bit          err;
    int          lat, k1, k2, req_end;
    logic [31:0] e_addr, e_wdata, e_data;
    logic        e_wen;
    logic [3:0]  e_mask;

    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    ifu_req_valid  = iv;
    ifu_req_addr   = ia;
    lsu_req_valid  = lv;
    lsu_req_addr   = la;
    lsu_req_wen    = lwen;
    lsu_req_wdata  = lwd;
    lsu_req_wmask  = lmask;
    #1;
    g = (iv && lv) ? !last_g : lv;
    check1("ifu_ready", ifu_req_ready, !g);
    check1("lsu_ready", lsu_req_ready, g);
    last_g  = g;
    e_addr  = g ? la : ia;
    e_wen   = g ? lwen : 1'b0;
    e_wdata = g ? lwd : 32'd0;
    e_mask  = g ? lmask : 4'd0;
    model(d1, d2, lat, err, k1, k2);
    e_data  = (err || e_wen) ? 32'd0 : rdata;
    req_end = (k1 < To - 1) ? k1 : To - 1;

    for (int k = 1; k <= lat + 1; k++) begin
      @(posedge sys_clk);
      #1;
      check1("busy", busy, k <= lat);
      check1("mem_valid", mem_req_valid, k <= req_end);
      if (k <= req_end) begin
        check32("mem_addr", mem_req_addr, e_addr);
        check1("mem_wen", mem_req_wen, e_wen);
        check32("mem_wdata", mem_req_wdata, e_wdata);
        check32("mem_wmask", {28'd0, mem_req_wmask}, {28'd0, e_mask});
      end
      check1("ifu_rvalid", ifu_resp_valid, (k == lat) && !g);
      check1("lsu_rvalid", lsu_resp_valid, (k == lat) && g);
      check32("ifu_rdata", ifu_resp_data, ((k == lat) && !g) ? e_data : 32'd0);
      check32("lsu_rdata", lsu_resp_data, ((k == lat) && g) ? e_data : 32'd0);
      check1("ifu_rerr", ifu_resp_err, (k == lat) && !g && err);
      check1("lsu_rerr", lsu_resp_err, (k == lat) && g && err);
      if (k <= lat) begin
        mem_req_ready  = (k == k1);
        mem_resp_valid = (k == k2);
        mem_resp_data  = (k == k2) ? rdata : $urandom;
        #1;
        check1("ifu_ready_busy", ifu_req_ready, 1'b0);
        check1("lsu_ready_busy", lsu_req_ready, 1'b0);
      end
    end
  endtask

  initial begin
    int          r;
    logic [31:0] a0, a1, wd, rd;

    // Reset state
    sys_rst = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst = 1'b1;
    last_g  = 1'b1;
    check_idle_outputs("reset");
    check32("reset_addr", mem_req_addr, 32'd0);
    check1("reset_wen", mem_req_wen, 1'b0);
    check32("reset_wdata", mem_req_wdata, 32'd0);
    check32("reset_wmask", {28'd0, mem_req_wmask}, 32'd0);
    check1("reset_ifu_ready", ifu_req_ready, 1'b0);
    check1("reset_lsu_ready", lsu_req_ready, 1'b0);

    // Both requesting from reset: IFU, LSU, IFU, LSU
    for (int i = 0; i < 4; i++) begin
      run_txn(1'b1, 1'b1, 32'h8000_0000 + 32'(i * 4), 32'h9000_0000 + 32'(i * 4), 1'b0,
              32'd0, 4'hf, 0, 0, 32'h1000 + 32'(i));
    end

    // IFU read alone, minimum latency
    run_txn(1'b1, 1'b0, 32'h8000_0000, 32'd0, 1'b0, 32'd0, 4'd0, 0, 0, 32'h0000_0413);

    // LSU write held in REQ for a few cycles; response data must be 0
    run_txn(1'b0, 1'b1, 32'd0, 32'h8000_1004, 1'b1, 32'hA5A5_A5A5, 4'b0011, 3, 1,
            32'hDEAD_BEEF);

    // Slave holds ready low 5 cycles, then responds
    run_txn(1'b1, 1'b0, 32'h8000_0040, 32'd0, 1'b0, 32'd0, 4'd0, 5, 0, 32'h1234_5678);

    // Completion near the deadline: in time, coinciding, one cycle late
    run_txn(1'b1, 1'b0, 32'h8000_0100, 32'd0, 1'b0, 32'd0, 4'd0, 0, 12, 32'h1111_1111);
    run_txn(1'b0, 1'b1, 32'd0, 32'h8000_0200, 1'b0, 32'd0, 4'hf, 0, 13, 32'h2222_2222);
    run_txn(1'b1, 1'b0, 32'h8000_0300, 32'd0, 1'b0, 32'd0, 4'd0, 0, 14, 32'h3333_3333);

    // Slave never responds, then a late response must be ignored
    run_txn(1'b0, 1'b1, 32'd0, 32'h8000_2000, 1'b0, 32'd0, 4'hf, 0, 1000, 32'h4444_4444);
    ifu_req_valid  = 1'b0;
    lsu_req_valid  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h5555_5555;
    for (int i = 0; i < 3; i++) begin
      @(posedge sys_clk);
      #1;
      mem_resp_valid = 1'b0;
      check_idle_outputs("late_resp");
    end

    // Slave never accepts: timeout in REQ withdraws mem_req_valid
    run_txn(1'b1, 1'b0, 32'h8000_3000, 32'd0, 1'b0, 32'd0, 4'd0, 100, 0, 32'h6666_6666);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      r  = $urandom_range(1, 3);
      a0 = $urandom;
      a1 = $urandom;
      wd = $urandom;
      rd = $urandom;
      run_txn(r[0], r[1], a0, a1, 1'($urandom_range(0, 1)), wd, 4'($urandom_range(0, 15)),
              $urandom_range(0, 5), $urandom_range(0, 15), rd);
    end

    // Reset during WAIT aborts silently; first tie afterwards goes to IFU
    ifu_req_valid  = 1'b1;
    lsu_req_valid  = 1'b0;
    ifu_req_addr   = 32'h8000_4000;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    @(posedge sys_clk);
    #1;
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(posedge sys_clk);
    #1;
    mem_req_ready = 1'b0;
    @(posedge sys_clk);
    #1;
    check1("wait_busy", busy, 1'b1);
    check1("wait_mvalid", mem_req_valid, 1'b0);
    sys_rst = 1'b0;
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b1;
    last_g  = 1'b1;
    check_idle_outputs("mid_reset");
    check32("mid_reset_addr", mem_req_addr, 32'd0);
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h7777_7777;
    @(posedge sys_clk);
    #1;
    mem_resp_valid = 1'b0;
    check_idle_outputs("post_reset");
    run_txn(1'b1, 1'b1, 32'h8000_5000, 32'h8000_6000, 1'b1, 32'h0, 4'hf, 0, 0, 32'h8888_8888);

    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    @(posedge sys_clk);
    #1;
    check_idle_outputs("end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
